// File: rtl/seq_gen.sv
// seq_gen: Simon Says colour sequencer expanding a latched seed through a Galois LFSR
// clk         rising-edge clock
// reset       asynchronous active-low reset
// seed/start  seed sampled on the start pulse, which begins a new game from any state
// color_*     playback of the first level colours over a valid/ready handshake
// btn_*       player presses, checked against the same colours
// match/mismatch/round_done  registered one-cycle result pulses
// win/level/busy             game status
module seq_gen #(
    parameter int          MAX_LEN = 32,
    parameter logic [31:0] TAPS    = 32'h8020_0003,
    parameter int          LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   seed,
    input  logic          start,
    output logic [1:0]    color_out,
    output logic          color_valid,
    input  logic          color_ready,
    input  logic          btn_valid,
    input  logic [1:0]    btn_color,
    output logic          match,
    output logic          mismatch,
    output logic          round_done,
    output logic          win,
    output logic [LW-1:0] level,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, PLAY, LISTEN, FAIL, WIN} state_t;
    state_t        state;
    logic [31:0]   base;
    logic [31:0]   lfsr;
    logic [31:0]   lfsr_nxt;
    logic [LW-1:0] idx;
    logic          last;
    logic          hit;
    always_comb begin
        lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
        last     = idx == level - LW'(1);
        hit      = btn_color == lfsr[1:0];
    end
    assign color_out = lfsr[1:0];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            base        <= 32'h1;
            lfsr        <= 32'h1;
            idx         <= '0;
            level       <= '0;
            match       <= 1'b0;
            mismatch    <= 1'b0;
            round_done  <= 1'b0;
            color_valid <= 1'b0;
            win         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            match      <= 1'b0;
            mismatch   <= 1'b0;
            round_done <= 1'b0;
            if (start) begin
                // a zero seed would lock the LFSR at zero
                base        <= seed == 32'h0 ? 32'h1 : seed;
                lfsr        <= seed == 32'h0 ? 32'h1 : seed;
                idx         <= '0;
                level       <= LW'(1);
                state       <= PLAY;
                color_valid <= 1'b1;
                busy        <= 1'b1;
                win         <= 1'b0;
            end else begin
                case (state)
                    PLAY: if (color_ready) begin
                        if (last) begin
                            lfsr        <= base;
                            idx         <= '0;
                            state       <= LISTEN;
                            color_valid <= 1'b0;
                        end else begin
                            lfsr <= lfsr_nxt;
                            idx  <= idx + LW'(1);
                        end
                    end
                    LISTEN: if (btn_valid) begin
                        if (!hit) begin
                            mismatch <= 1'b1;
                            state    <= FAIL;
                            busy     <= 1'b0;
                        end else begin
                            match <= 1'b1;
                            if (!last) begin
                                lfsr <= lfsr_nxt;
                                idx  <= idx + LW'(1);
                            end else if (level == LW'(MAX_LEN)) begin
                                state <= WIN;
                                win   <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                round_done  <= 1'b1;
                                level       <= level + LW'(1);
                                lfsr        <= base;
                                idx         <= '0;
                                state       <= PLAY;
                                color_valid <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
